// File: rtl/asg_seg_ch.sv
// asg_seg_ch - multi-segment arbitrary signal generator channel.
// Plays a sequence of waveform segments from a 2**RSZ sample RAM after a
// trigger, then applies gain, DC offset and saturation for one DAC channel.
// Optional feature: define ASG_SEG_LOOP_EN to let set_loop_i restart the
// sequence at segment 0 instead of returning to IDLE.
// Ports:
//   dac_clk_i/dac_rst_i          clock, async active-high reset
//   buf_we_i/addr/wdata/rdata_o  waveform RAM write and read-back (1 cycle)
//   seg_we_i/idx/start/len/step/ncyc/last  descriptor table write
//   arm_i/stop_i/trig_i          sequence control pulses
//   set_loop_i/amp/dc/idle       playback settings
//   dac_o, busy_o, seg_o, done_o DAC data and status
module asg_seg_ch #(
   parameter int unsigned DW   = 14,
   parameter int unsigned RSZ  = 14,
   parameter int unsigned NSEG = 4
) (
   input  logic                    dac_clk_i,
   input  logic                    dac_rst_i,
   input  logic                    buf_we_i,
   input  logic [RSZ-1:0]          buf_addr_i,
   input  logic [DW-1:0]           buf_wdata_i,
   output logic [DW-1:0]           buf_rdata_o,
   input  logic                    seg_we_i,
   input  logic [$clog2(NSEG)-1:0] seg_idx_i,
   input  logic [RSZ-1:0]          seg_start_i,
   input  logic [RSZ:0]            seg_len_i,
   input  logic [RSZ+15:0]         seg_step_i,
   input  logic [15:0]             seg_ncyc_i,
   input  logic                    seg_last_i,
   input  logic                    arm_i,
   input  logic                    stop_i,
   input  logic                    trig_i,
   input  logic                    set_loop_i,
   input  logic [DW-1:0]           set_amp_i,
   input  logic [DW-1:0]           set_dc_i,
   input  logic [DW-1:0]           set_idle_i,
   output logic [DW-1:0]           dac_o,
   output logic                    busy_o,
   output logic [$clog2(NSEG)-1:0] seg_o,
   output logic                    done_o
);

   localparam int unsigned IW    = $clog2(NSEG);
   localparam int unsigned LW    = RSZ + 1;   // segment length
   localparam int unsigned PW    = RSZ + 16;  // pointer / step, 16 fraction bits
   localparam int unsigned NW    = RSZ + 17;  // pointer sum and limit
   localparam int unsigned DEPTH = 1 << RSZ;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   // Descriptor table, written by software, deliberately not reset
   logic [RSZ-1:0] tab_start_q [NSEG];
   logic [LW-1:0]  tab_len_q   [NSEG];
   logic [PW-1:0]  tab_step_q  [NSEG];
   logic [15:0]    tab_ncyc_q  [NSEG];
   logic           tab_last_q  [NSEG];

   always_ff @(posedge dac_clk_i) begin
      if (seg_we_i && (32'(seg_idx_i) < NSEG)) begin
         tab_start_q[seg_idx_i] <= seg_start_i;
         tab_len_q[seg_idx_i]   <= seg_len_i;
         tab_step_q[seg_idx_i]  <= seg_step_i;
         tab_ncyc_q[seg_idx_i]  <= seg_ncyc_i;
         tab_last_q[seg_idx_i]  <= seg_last_i;
      end
   end

   // Waveform RAM write port
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge dac_clk_i) begin
      if (buf_we_i) mem[buf_addr_i] <= buf_wdata_i;
   end

   logic loop_c;
`ifdef ASG_SEG_LOOP_EN
   assign loop_c = set_loop_i;
`else
   logic unused_loop_c;
   assign unused_loop_c = set_loop_i;
   assign loop_c        = 1'b0;
`endif

   // Sequencer state and working copy of the active descriptor
   logic [1:0]     state_q, state_d;
   logic [RSZ-1:0] start_q, start_d;
   logic [LW-1:0]  len_q, len_d;
   logic [PW-1:0]  step_q, step_d;
   logic [15:0]    cnt_q, cnt_d;
   logic           last_q, last_d;
   logic [PW-1:0]  rel_q, rel_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [RSZ-1:0] addr_q, addr_d;
   logic           v0_q, v0_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           ent_c;
   logic [IW-1:0]  ent_idx_c;
   logic [NW-1:0]  sum_c, lim_c;

   // Next-state: pointer advance, segment chaining and control
   always_comb begin
      state_d   = state_q;
      start_d   = start_q;
      len_d     = len_q;
      step_d    = step_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      rel_d     = rel_q;
      idx_d     = idx_q;
      v0_d      = 1'b0;
      done_d    = 1'b0;
      ent_c     = 1'b0;
      ent_idx_c = '0;
      sum_c     = {1'b0, rel_q} + {1'b0, step_q};
      lim_c     = {len_q, 16'h0000};

      case (state_q)
         ST_IDLE: begin
            if (arm_i) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (trig_i) begin
               state_d = ST_RUN;
               ent_c   = 1'b1;
            end
         end
         ST_RUN: begin
            v0_d = 1'b1;
            if (sum_c < lim_c) begin
               rel_d = PW'(sum_c);
            end else begin
               // wrap keeps the fractional remainder
               rel_d = PW'(sum_c - lim_c);
               if (cnt_q == 16'd1) begin
                  if (last_q || (idx_q == IW'(NSEG - 1))) begin
                     done_d = 1'b1;
                     if (loop_c) begin
                        ent_c = 1'b1;
                     end else begin
                        state_d = ST_IDLE;
                        v0_d    = 1'b0;
                     end
                  end else begin
                     ent_c     = 1'b1;
                     ent_idx_c = idx_q + IW'(1);
                  end
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (stop_i) begin
         state_d = ST_IDLE;
         ent_c   = 1'b0;
         v0_d    = 1'b0;
         done_d  = 1'b0;
      end

      // Segment entry: first address of the new segment issues this edge
      if (ent_c) begin
         start_d = tab_start_q[ent_idx_c];
         len_d   = (tab_len_q[ent_idx_c] == '0) ? LW'(1) : tab_len_q[ent_idx_c];
         step_d  = tab_step_q[ent_idx_c];
         cnt_d   = (tab_ncyc_q[ent_idx_c] == 16'd0) ? 16'd1 : tab_ncyc_q[ent_idx_c];
         last_d  = tab_last_q[ent_idx_c];
         rel_d   = '0;
         idx_d   = ent_idx_c;
         v0_d    = 1'b1;
      end

      busy_d = (state_d == ST_RUN);
      addr_d = start_d + rel_d[PW-1:16];
   end

   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i) begin
         state_q <= ST_IDLE;
         start_q <= '0;
         len_q   <= LW'(1);
         step_q  <= '0;
         cnt_q   <= 16'd1;
         last_q  <= 1'b0;
         rel_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         v0_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         len_q   <= len_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         rel_q   <= rel_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         v0_q    <= v0_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Data path: RAM read, select, multiply, offset/saturate
   logic [DW-1:0]   ram_q, rdata_q, sel_q, dac_q;
   logic            v1_q;
   logic [DW:0]     prod_q;
   logic [2*DW-1:0] prod_c;
   logic [DW-2:0]   unused_prod_lo_c;
   logic [DW+1:0]   acc_c;
   logic            ovf_c;
   logic [DW-1:0]   dac_d;

   // Signed sample times unsigned gain; true result fits 2*DW bits
   assign prod_c           = {{DW{sel_q[DW-1]}}, sel_q} * {{DW{1'b0}}, set_amp_i};
   assign unused_prod_lo_c = prod_c[DW-2:0];
   assign acc_c            = {prod_q[DW], prod_q} + {{2{set_dc_i[DW-1]}}, set_dc_i};
   assign ovf_c            = (acc_c[DW+1:DW-1] != 3'b000) && (acc_c[DW+1:DW-1] != 3'b111);
   assign dac_d            = !ovf_c ? acc_c[DW-1:0]
                           : (acc_c[DW+1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});

   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i) begin
         ram_q   <= '0;
         rdata_q <= '0;
         v1_q    <= 1'b0;
         sel_q   <= '0;
         prod_q  <= '0;
         dac_q   <= '0;
      end else begin
         ram_q   <= mem[addr_q];
         rdata_q <= mem[buf_addr_i];
         v1_q    <= v0_q;
         sel_q   <= v1_q ? ram_q : set_idle_i;
         prod_q  <= prod_c[2*DW-1:DW-1];
         dac_q   <= dac_d;
      end
   end

   assign buf_rdata_o = rdata_q;
   assign dac_o       = dac_q;
   assign busy_o      = busy_q;
   assign seg_o       = idx_q;
   assign done_o      = done_q;

endmodule
